// File: rtl/sweep_acq_pkg.sv
// -----------------------------------------------------------------------------
// sweep_acq_pkg
// Shared definitions for the SWEEP_ACQ sequencer and the mode switcher:
//   - sweep_state_e : sequencer FSM state encoding
//   - mode_e        : acquisition mode constants shared with the switcher
//   - sweep_cfg_t   : sweep parameters latched at sweep start
//   - HEADER_TAG / TRAILER_WORD and header_word() for the USB record format
// -----------------------------------------------------------------------------
package sweep_acq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_SC,
    ST_WAIT_SC,
    ST_SETTLE,
    ST_ACQ,
    ST_DRAIN,
    ST_HDR,
    ST_CNT,
    ST_NEXT,
    ST_TRAILER,
    ST_DONE
  } sweep_state_e;

  typedef enum logic [1:0] {
    MODE_ACQ       = 2'd0,
    MODE_SCURVE    = 2'd1,
    MODE_SWEEP_ACQ = 2'd2
  } mode_e;

  typedef struct packed {
    logic [9:0]  start_dac;
    logic [9:0]  end_dac;
    logic [9:0]  dac_step;
    logic [15:0] max_words;
    logic [15:0] acq_window;
  } sweep_cfg_t;

  localparam logic [3:0]  HEADER_TAG   = 4'hD;
  localparam logic [15:0] TRAILER_WORD = 16'hFF45;

  // Per-point header: tag in the top nibble, DAC code in the low 10 bits.
  function automatic logic [15:0] header_word(input logic [9:0] code);
    return {HEADER_TAG, 2'b00, code};
  endfunction

endpackage

// File: rtl/sweep_acq_controller_if.sv
// -----------------------------------------------------------------------------
// sweep_acq_controller_if
// Bundles the sweep controller's control/status/data signals.
//   master : the sweep controller (consumes run level, sweep config,
//            SC-done and word strobe; drives DAC code, SC load, acq gate,
//            USB data/strobe, done and USB enable)
//   slave  : the surrounding switcher / Microroc / USB side
// -----------------------------------------------------------------------------
interface sweep_acq_controller_if;
  logic        SweepStartStop;
  logic [9:0]  StartDac;
  logic [9:0]  EndDac;
  logic [9:0]  DacStep;
  logic [15:0] MaxWordNumber;
  logic [15:0] AcqTimeWindow;
  logic        SCConfigDone;
  logic        ParallelData_en;

  logic [9:0]  SweepAcq10BitDac;
  logic        SweepAcqMicrorocSCParameterLoad;
  logic        SweepAcqMicrorocAcqStartStop;
  logic [15:0] SweepAcqData;
  logic        SweepAcqData_en;
  logic        SweepAcqDone;
  logic        SweepTestUsbStartStop;

  modport master (
    input  SweepStartStop, StartDac, EndDac, DacStep, MaxWordNumber,
           AcqTimeWindow, SCConfigDone, ParallelData_en,
    output SweepAcq10BitDac, SweepAcqMicrorocSCParameterLoad,
           SweepAcqMicrorocAcqStartStop, SweepAcqData, SweepAcqData_en,
           SweepAcqDone, SweepTestUsbStartStop
  );

  modport slave (
    output SweepStartStop, StartDac, EndDac, DacStep, MaxWordNumber,
           AcqTimeWindow, SCConfigDone, ParallelData_en,
    input  SweepAcq10BitDac, SweepAcqMicrorocSCParameterLoad,
           SweepAcqMicrorocAcqStartStop, SweepAcqData, SweepAcqData_en,
           SweepAcqDone, SweepTestUsbStartStop
  );
endinterface

// File: rtl/acq_window_timer.sv
// -----------------------------------------------------------------------------
// acq_window_timer
// Microsecond prescaler plus saturating 16-bit microsecond counter that bounds
// one acquisition window.
//   Clk, reset  : clock, asynchronous active-high reset
//   clear_i     : synchronous clear of prescaler and counter (wins over enable)
//   enable_i    : count while high
//   window_i    : window length in us; 0 disables expiry
//   expire_o    : high in the last clock of the window, so the caller leaves
//                 after exactly window_i * CLK_PER_US enabled cycles
// -----------------------------------------------------------------------------
module acq_window_timer #(
  parameter int CLK_PER_US = 40
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic [15:0] window_i,
  output logic        expire_o
);

  localparam int            PW         = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_US - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   us_q, us_d;
  logic          tick;
  logic [16:0]   us_next;

  assign tick = enable_i && (presc_q == PRESC_LAST);

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    presc_d = presc_q;
    us_d    = us_q;
    if (clear_i) begin
      presc_d = '0;
      us_d    = '0;
    end else if (enable_i) begin
      if (tick) begin
        presc_d = '0;
        if (us_q != 16'hFFFF) us_d = us_q + 16'd1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      us_q    <= '0;
    end else begin
      presc_q <= presc_d;
      us_q    <= us_d;
    end
  end

  // Look one tick ahead so expiry lines up with the final cycle of the window.
  assign us_next  = {1'b0, us_q} + {16'b0, tick};
  assign expire_o = enable_i && (window_i != 16'd0) && (us_next >= {1'b0, window_i});

endmodule

// File: rtl/sweep_acq_controller.sv
// -----------------------------------------------------------------------------
// sweep_acq_controller
// SWEEP_ACQ sequencer: steps the 10-bit Microroc DAC from StartDac to EndDac,
// reloading slow control and running one gated acquisition per point, then
// writes {header, word count} per point and a trailer to the USB FIFO.
//   Clk, reset : clock, asynchronous active-high reset
//   acq_if     : sweep_acq_controller_if.master (run level, sweep config,
//                SC-done, word strobe in; DAC, SC load, acq gate, USB data,
//                done, USB enable out)
// -----------------------------------------------------------------------------
module sweep_acq_controller
  import sweep_acq_pkg::*;
#(
  parameter int CLK_PER_US       = 40,
  parameter int SC_SETTLE_CYCLES = 400,
  parameter int DRAIN_CYCLES     = 64
) (
  input  logic                          Clk,
  input  logic                          reset,
  sweep_acq_controller_if.master        acq_if
);

  sweep_state_e state_q, state_d;
  sweep_cfg_t   cfg_q, cfg_d;
  logic [9:0]   dac_q, dac_d;
  logic [15:0]  word_cnt_q, word_cnt_d;
  logic [15:0]  cyc_q, cyc_d;
  logic         start_q;

  logic         start_rise;
  logic         timer_expire;
  logic         word_limit_hit;
  logic [9:0]   step_eff;
  logic [10:0]  dac_sum;

  logic [9:0]   dac_o;
  logic         sc_load_o, acq_gate_o, data_en_o, done_o, usb_o;
  logic [15:0]  data_o;

  assign start_rise     = acq_if.SweepStartStop & ~start_q;
  assign step_eff       = (cfg_q.dac_step == 10'd0) ? 10'd1 : cfg_q.dac_step;
  // 11-bit sum so an overshoot past 1023 is seen as "past the end", never wraps.
  assign dac_sum        = {1'b0, dac_q} + {1'b0, step_eff};
  assign word_limit_hit = (cfg_q.max_words != 16'd0) && (word_cnt_q >= cfg_q.max_words);

  acq_window_timer #(.CLK_PER_US(CLK_PER_US)) u_timer (
    .Clk      (Clk),
    .reset    (reset),
    .clear_i  (state_q != ST_ACQ),
    .enable_i (state_q == ST_ACQ),
    .window_i (cfg_q.acq_window),
    .expire_o (timer_expire)
  );

  // State register
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cfg_q      <= '0;
      dac_q      <= '0;
      word_cnt_q <= '0;
      cyc_q      <= '0;
      // NOTE: the edge detector resets to 1 so a run level already high when
      // reset releases is not mistaken for a fresh start request.
      start_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      dac_q      <= dac_d;
      word_cnt_q <= word_cnt_d;
      cyc_q      <= cyc_d;
      start_q    <= acq_if.SweepStartStop;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    dac_d      = dac_q;
    word_cnt_d = word_cnt_q;
    cyc_d      = '0;

    // Late words keep counting through DRAIN; count saturates at 0xFFFF.
    if ((state_q == ST_ACQ || state_q == ST_DRAIN) && acq_if.ParallelData_en &&
        word_cnt_q != 16'hFFFF)
      word_cnt_d = word_cnt_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          cfg_d      = '{start_dac:  acq_if.StartDac,
                         end_dac:    acq_if.EndDac,
                         dac_step:   acq_if.DacStep,
                         max_words:  acq_if.MaxWordNumber,
                         acq_window: acq_if.AcqTimeWindow};
          dac_d      = acq_if.StartDac;
          word_cnt_d = '0;
          state_d    = ST_LOAD_SC;
        end
      end
      ST_LOAD_SC: state_d = ST_WAIT_SC;
      ST_WAIT_SC: if (acq_if.SCConfigDone) state_d = ST_SETTLE;
      ST_SETTLE: begin
        cyc_d = cyc_q + 16'd1;
        if (cyc_q == 16'(SC_SETTLE_CYCLES - 1)) state_d = ST_ACQ;
      end
      ST_ACQ: if (word_limit_hit || timer_expire) state_d = ST_DRAIN;
      ST_DRAIN: begin
        cyc_d = cyc_q + 16'd1;
        if (cyc_q == 16'(DRAIN_CYCLES - 1)) state_d = ST_HDR;
      end
      ST_HDR: state_d = ST_CNT;
      ST_CNT: state_d = ST_NEXT;
      ST_NEXT: begin
        if (dac_q >= cfg_q.end_dac || dac_sum > {1'b0, cfg_q.end_dac}) begin
          state_d = ST_TRAILER;
        end else begin
          dac_d      = dac_sum[9:0];
          word_cnt_d = '0;
          state_d    = ST_LOAD_SC;
        end
      end
      ST_TRAILER: state_d = ST_DONE;
      ST_DONE: if (!acq_if.SweepStartStop) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Dropping the run level aborts from anywhere mid-sweep.
    if (state_q != ST_IDLE && state_q != ST_DONE && !acq_if.SweepStartStop)
      state_d = ST_IDLE;
  end

  // Outputs
  always_comb begin
    dac_o      = '0;
    sc_load_o  = 1'b0;
    acq_gate_o = 1'b0;
    data_o     = '0;
    data_en_o  = 1'b0;
    done_o     = 1'b0;
    usb_o      = 1'b0;

    case (state_q)
      ST_LOAD_SC: sc_load_o  = 1'b1;
      ST_ACQ:     acq_gate_o = 1'b1;
      ST_HDR: begin
        data_o    = header_word(dac_q);
        data_en_o = 1'b1;
      end
      ST_CNT: begin
        data_o    = word_cnt_q;
        data_en_o = 1'b1;
      end
      ST_TRAILER: begin
        data_o    = TRAILER_WORD;
        data_en_o = 1'b1;
      end
      ST_DONE:    done_o = 1'b1;
      default: ;
    endcase

    if (state_q != ST_IDLE) dac_o = dac_q;
    usb_o = (state_q != ST_IDLE) && (state_q != ST_DONE);

    // A record word due in the same cycle the run level drops is suppressed.
    if (!acq_if.SweepStartStop) begin
      data_o    = '0;
      data_en_o = 1'b0;
    end
  end

  assign acq_if.SweepAcq10BitDac                = dac_o;
  assign acq_if.SweepAcqMicrorocSCParameterLoad = sc_load_o;
  assign acq_if.SweepAcqMicrorocAcqStartStop    = acq_gate_o;
  assign acq_if.SweepAcqData                    = data_o;
  assign acq_if.SweepAcqData_en                 = data_en_o;
  assign acq_if.SweepAcqDone                    = done_o;
  assign acq_if.SweepTestUsbStartStop           = usb_o;

endmodule
